ctx_spill_engine: RTL and testbench
===================================

# ctx_spill_engine

Interrupt context spill/fill engine for the CX-CPU core. On interrupt entry it reads the architecturally preserved registers (r1–r5, GP, SP, FP, RA) out of the register file and stores them as a 9-word frame in data memory. On interrupt return it loads that frame back and writes each word into the register file through the normal write port. It sits beside the register file and the data-memory port, and holds `busy_o` high so the pipeline stalls while it owns both.

## Interface
- `ADDR_WIDTH`, 5: register-file address width.
- `DATA_WIDTH`, 32: register and memory word width.
- `MEM_ADDR_WIDTH`, 32: byte address width of the memory port.

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `save_i` in 1: spill request, sampled in IDLE only.
- `restore_i` in 1: fill request, sampled in IDLE only.
- `frame_base_i` in MEM_ADDR_WIDTH: frame byte base, captured on request acceptance.
- `busy_o` out 1: engine owns the register file and memory port.
- `done_o` out 1: one-cycle completion pulse.
- `rf_raddr_o` out ADDR_WIDTH: register-file read address.
- `rf_rdata_i` in DATA_WIDTH: register-file read data, combinational from `rf_raddr_o`.
- `rf_we_o` out 1: register-file write enable.
- `rf_waddr_o` out ADDR_WIDTH: register-file write address.
- `rf_wdata_o` out DATA_WIDTH: register-file write data.
- `mem_req_o` out 1: memory request valid.
- `mem_we_o` out 1: 1 = store, 0 = load.
- `mem_addr_o` out MEM_ADDR_WIDTH: byte address.
- `mem_wdata_o` out DATA_WIDTH: store data.
- `mem_ready_i` in 1: request accepted when `mem_req_o && mem_ready_i`.
- `mem_rvalid_i` in 1: load data valid.
- `mem_rdata_i` in DATA_WIDTH: load data.

## Operation
- Slot index `idx` runs 0..8 and maps to registers 1, 2, 3, 4, 5, 28 (GP), 29 (SP), 30 (FP), 31 (RA).
- Slot address = `base + 4*idx`, computed modulo 2^MEM_ADDR_WIDTH, so it wraps. Low address bits are passed through unchecked.
- States:
  - IDLE, SAVE_RD, SAVE_WR, FILL_RQ, FILL_WAIT, FILL_WB, DONE.
- IDLE:
  - `save_i` → capture base, `idx`=0, go to SAVE_RD.
  - Otherwise `restore_i` → capture base, `idx`=0, go to FILL_RQ.
  - If both are high, save wins. Requests in any other state are ignored (not queued).
- SAVE_RD: drive `rf_raddr_o`=reg(idx). Register `rf_rdata_i` into the `mem_wdata_o` holding register. Go to SAVE_WR.
- SAVE_WR: drive `mem_req_o`=1, `mem_we_o`=1, `mem_addr_o`=slot. Hold all three stable until `mem_ready_i`.
  - On handshake: if `idx`==8 go to DONE, else `idx`+1 and go to SAVE_RD.
- FILL_RQ: drive `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`=slot. Hold until `mem_ready_i`, then go to FILL_WAIT.
- FILL_WAIT: wait for `mem_rvalid_i`. Capture `mem_rdata_i` into `rf_wdata_o` and set `rf_waddr_o`=reg(idx). Go to FILL_WB.
- FILL_WB: `rf_we_o`=1 for exactly this cycle.
  - If `idx`==8 go to DONE, else `idx`+1 and go to FILL_RQ.
- DONE: `done_o`=1 for one cycle, then return to IDLE.
- `busy_o` = (state != IDLE), DONE included.
- At most one memory transaction is outstanding. `mem_rvalid_i` outside FILL_WAIT is ignored.
- Never writes register 0. Never touches registers 6–27. Register-file writes are emitted only in FILL_WB.
- Reset asserted mid-operation: immediate return to IDLE, all outputs cleared, no done pulse. A partial frame is left in memory or the register file as-is.

## Timing
- Reset value of every output is 0. `idx` and the captured base also reset to 0.
- All outputs are registered or decoded from the state only; none is combinational from an input, except that `rf_rdata_i` is consumed in the same cycle `rf_raddr_o` is driven.
- Request sampled at edge T:
  - `busy_o` rises at T+1.
  - Save with `mem_ready_i` held at 1: 2 cycles per slot, so 18 cycles. DONE at T+19, `busy_o` falls at T+20.
  - Restore with `mem_ready_i`=1 and rvalid one cycle after acceptance: 3 cycles per slot, so 27 cycles. DONE at T+28.
- Each cycle of `mem_ready_i` low adds one cycle. Each extra cycle of rvalid latency adds one cycle.
- `mem_rvalid_i` arrives no earlier than the cycle after acceptance.

## Test plan
- Spill timing: regs r1..r5, r28..r31 preloaded 0x11..0x99, base=0x100, ready=1. Required: 9 stores at 0x100, 0x104, …, 0x120 with data 0x11..0x99 in that order; `done_o` at T+19; no `rf_we_o`.
- Fill timing: memory at 0x200..0x220 holds 0xA0..0xA8, base=0x200, rvalid latency 1. Required: writes reg1←0xA0 … reg31←0xA8 in that order, `done_o` at T+28, 9 `rf_we_o` pulses total.
- Backpressure: `mem_ready_i` low 3 cycles on slot 4 during a save. Required: `mem_addr_o`=base+0x10 and `mem_wdata_o` held stable throughout; done delayed exactly 3 cycles.
- Arbitration: `save_i` and `restore_i` together in IDLE, then `restore_i` pulsed while busy. Required: a save runs; the second request is dropped; one `done_o` only.
- Address wrap: base=0xFFFFFFF8. Required: slot addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, …, 0x18.
- Reset mid-fill: `rst` low during the FILL_WAIT of slot 3. Required: all outputs 0 asynchronously; IDLE after release; a late `mem_rvalid_i` is ignored; no `done_o`.

Source files
------------

// File: rtl/ctx_spill_engine.sv
// ctx_spill_engine
//   Interrupt context spill/fill engine. On a save request it reads the nine
//   preserved registers (r1-r5, r28-r31) and stores them as a 9-word frame at
//   frame_base_i. On a restore request it loads that frame back and writes
//   each word through the register-file write port. busy_o stalls the
//   pipeline while the engine owns the register file and the memory port.
//
// Ports
//   clk, rst           : clock; asynchronous active-low reset
//   save_i, restore_i  : spill / fill requests, sampled only in IDLE (save wins)
//   frame_base_i       : frame byte base, captured when a request is accepted
//   busy_o, done_o     : engine active; one-cycle completion pulse
//   rf_raddr_o/rdata_i : register-file read port (rdata combinational)
//   rf_we_o/waddr_o/wdata_o : register-file write port
//   mem_req_o/we_o/addr_o/wdata_o/ready_i : memory request channel
//   mem_rvalid_i/rdata_i : memory load response
module ctx_spill_engine #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      save_i,
    input  logic                      restore_i,
    input  logic [MEM_ADDR_WIDTH-1:0] frame_base_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [ADDR_WIDTH-1:0]     rf_raddr_o,
    input  logic [DATA_WIDTH-1:0]     rf_rdata_i,
    output logic                      rf_we_o,
    output logic [ADDR_WIDTH-1:0]     rf_waddr_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_ready_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE_RD,
        S_SAVE_WR,
        S_FILL_RQ,
        S_FILL_WAIT,
        S_FILL_WB,
        S_DONE
    } state_e;

    localparam logic [3:0] LAST_IDX = 4'd8;

    state_e                    state_q, state_d;
    logic [3:0]                idx_q, idx_d;
    logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
    logic [DATA_WIDTH-1:0]     st_data_q, st_data_d;
    logic [DATA_WIDTH-1:0]     ld_data_q, ld_data_d;
    logic [ADDR_WIDTH-1:0]     waddr_q, waddr_d;

    logic [ADDR_WIDTH-1:0]     slot_reg;
    logic [MEM_ADDR_WIDTH-1:0] slot_addr;

    // Slots 0..4 map to r1..r5, slots 5..8 map to r28..r31 (GP, SP, FP, RA).
    always_comb begin
        if (idx_q < 4'd5) begin
            slot_reg = ADDR_WIDTH'(idx_q) + ADDR_WIDTH'(1);
        end else begin
            slot_reg = ADDR_WIDTH'(idx_q) + ADDR_WIDTH'(23);
        end
    end

    // Plain modular add: a base near the top of the address space wraps to 0.
    assign slot_addr = base_q + MEM_ADDR_WIDTH'({idx_q, 2'b00});

    // NOTE: every register, data holding registers included, is reset so that
    // all outputs read 0 immediately when rst falls, even mid-operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            base_q    <= '0;
            st_data_q <= '0;
            ld_data_q <= '0;
            waddr_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q   <= state_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
            st_data_q <= st_data_d;
            ld_data_q <= ld_data_d;
            waddr_q   <= waddr_d;
        end
    end

    always_comb begin
        // NOTE: every signal written below gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d    = state_q;
        idx_d      = idx_q;
        base_d     = base_q;
        st_data_d  = st_data_q;
        ld_data_d  = ld_data_q;
        waddr_d    = waddr_q;
        done_o     = 1'b0;
        rf_raddr_o = '0;
        rf_we_o    = 1'b0;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;

        case (state_q)
            S_IDLE: begin
                if (save_i) begin
                    base_d  = frame_base_i;
                    idx_d   = '0;
                    state_d = S_SAVE_RD;
                end else if (restore_i) begin
                    base_d  = frame_base_i;
                    idx_d   = '0;
                    state_d = S_FILL_RQ;
                end
            end
            S_SAVE_RD: begin
                // Register-file read is combinational; capture it so the store
                // data stays stable however long the memory stalls.
                rf_raddr_o = slot_reg;
                st_data_d  = rf_rdata_i;
                state_d    = S_SAVE_WR;
            end
            S_SAVE_WR: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = slot_addr;
                if (mem_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_SAVE_RD;
                    end
                end
            end
            S_FILL_RQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = slot_addr;
                if (mem_ready_i) begin
                    state_d = S_FILL_WAIT;
                end
            end
            S_FILL_WAIT: begin
                // rvalid is only honoured here, so at most one load is in flight.
                if (mem_rvalid_i) begin
                    ld_data_d = mem_rdata_i;
                    waddr_d   = slot_reg;
                    state_d   = S_FILL_WB;
                end
            end
            S_FILL_WB: begin
                rf_we_o = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_FILL_RQ;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q != S_IDLE);
    assign rf_waddr_o  = waddr_q;
    assign rf_wdata_o  = ld_data_q;
    assign mem_wdata_o = st_data_q;

endmodule

// File: tb/tb_ctx_spill_engine.sv
// tb_ctx_spill_engine
//   Scoreboard bench for ctx_spill_engine. Stimulus pushes the expected
//   stores, loads, register writes and done latencies into queues; a monitor
//   sampling on the falling edge pops and compares as the DUT presents them.
//   A memory responder models ready backpressure and load latency.
module tb_ctx_spill_engine;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int MW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          save_i, restore_i;
    logic [MW-1:0] frame_base_i;
    logic          busy_o, done_o;
    logic [AW-1:0] rf_raddr_o;
    logic [DW-1:0] rf_rdata_i;
    logic          rf_we_o;
    logic [AW-1:0] rf_waddr_o;
    logic [DW-1:0] rf_wdata_o;
    logic          mem_req_o, mem_we_o;
    logic [MW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ready_i, mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;

    ctx_spill_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MW)) dut (
        .clk          (clk),
        .rst          (rst),
        .save_i       (save_i),
        .restore_i    (restore_i),
        .frame_base_i (frame_base_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .rf_raddr_o   (rf_raddr_o),
        .rf_rdata_i   (rf_rdata_i),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ready_i  (mem_ready_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Register-file and memory models (written by stimulus only).
    logic [DW-1:0] rf_model [32];
    logic [DW-1:0] mem_model [logic [MW-1:0]];
    assign rf_rdata_i = rf_model[rf_raddr_o];

    typedef struct packed { logic [MW-1:0] addr; logic [DW-1:0] data; } store_t;
    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } rfw_t;

    store_t        exp_store[$];
    rfw_t          exp_rfw[$];
    logic [MW-1:0] exp_load[$];
    int            exp_done[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [AW-1:0] reg_of(input int i);
        return (i < 5) ? AW'(i + 1) : AW'(i + 23);
    endfunction

    function automatic logic [127:0] outs();
        return 128'({busy_o, done_o, rf_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o,
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o});
    endfunction

    // Responder controls (set by stimulus, read by responder).
    logic [MW-1:0] stall_addr  = 32'h1;
    int            stall_cycles = 0;
    logic [MW-1:0] block_addr  = 32'h1;
    int            rv_extra    = 0;

    // Responder state.
    logic          hs_load;
    logic [MW-1:0] hs_addr;
    int            stall_run  = 0;
    bit            rv_pending = 1'b0;
    int            rv_wait    = 0;
    logic [DW-1:0] rv_data    = '0;

    initial begin
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            hs_load = mem_req_o && mem_ready_i && !mem_we_o;
            hs_addr = mem_addr_o;
            @(posedge clk);
            #1;
            mem_rvalid_i = 1'b0;
            if (hs_load) begin
                rv_pending = 1'b1;
                rv_wait    = (hs_addr == block_addr) ? 8 : rv_extra;
                rv_data    = mem_model.exists(hs_addr) ? mem_model[hs_addr] : '0;
            end
            if (rv_pending) begin
                if (rv_wait == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = rv_data;
                    rv_pending   = 1'b0;
                end else begin
                    rv_wait--;
                end
            end
            if (mem_req_o && mem_addr_o == stall_addr && stall_run < stall_cycles) begin
                mem_ready_i = 1'b0;
                stall_run++;
            end else begin
                mem_ready_i = 1'b1;
                if (!(mem_req_o && mem_addr_o == stall_addr)) stall_run = 0;
            end
        end
    end

    // Monitor state.
    int            busy_cnt  = 0;
    int            done_cnt  = 0;
    int            rfw_cnt   = 0;
    int            load_cnt  = 0;
    int            stall_cnt = 0;
    bit            prev_stall = 1'b0;
    logic [MW-1:0] prev_addr;
    logic [DW-1:0] prev_wdata;
    logic          prev_we;

    initial begin
        store_t s;
        rfw_t   w;
        forever begin
            @(negedge clk);
            if (busy_o) busy_cnt++; else busy_cnt = 0;
            if (mem_req_o && mem_ready_i) begin
                if (mem_we_o) begin
                    if (exp_store.size() == 0) check("store_unexpected", mem_addr_o, 128'h0);
                    else begin
                        s = exp_store.pop_front();
                        check("store_addr", mem_addr_o, s.addr);
                        check("store_data", mem_wdata_o, s.data);
                    end
                end else begin
                    load_cnt++;
                    if (exp_load.size() == 0) check("load_unexpected", mem_addr_o, 128'h0);
                    else check("load_addr", mem_addr_o, exp_load.pop_front());
                end
            end
            if (rf_we_o) begin
                rfw_cnt++;
                if (exp_rfw.size() == 0) check("rf_write_unexpected", rf_waddr_o, 128'h0);
                else begin
                    w = exp_rfw.pop_front();
                    check("rf_waddr", rf_waddr_o, w.addr);
                    check("rf_wdata", rf_wdata_o, w.data);
                end
            end
            if (done_o) begin
                done_cnt++;
                if (exp_done.size() == 0) check("done_unexpected", 1'b1, 1'b0);
                else check("done_latency", busy_cnt, exp_done.pop_front());
            end
            if (prev_stall && mem_req_o) begin
                check("stall_addr_stable", mem_addr_o, prev_addr);
                check("stall_wdata_stable", mem_wdata_o, prev_wdata);
                check("stall_we_stable", mem_we_o, prev_we);
            end
            prev_stall = mem_req_o && !mem_ready_i;
            if (prev_stall) stall_cnt++;
            prev_addr  = mem_addr_o;
            prev_wdata = mem_wdata_o;
            prev_we    = mem_we_o;
        end
    end

    int start_done, start_rfw;

    task automatic preload_rf(input logic [DW-1:0] first, input logic [DW-1:0] step);
        for (int r = 0; r < 32; r++) rf_model[r] = 32'hBAD0_0000 | DW'(r);
        for (int i = 0; i < 9; i++) rf_model[reg_of(i)] = first + step * DW'(i);
    endtask

    task automatic push_save(input logic [MW-1:0] base, input logic [DW-1:0] first,
                             input logic [DW-1:0] step);
        store_t s;
        for (int i = 0; i < 9; i++) begin
            s.addr = base + MW'(4 * i);
            s.data = first + step * DW'(i);
            exp_store.push_back(s);
        end
    endtask

    task automatic issue(input logic sv, input logic rs, input logic [MW-1:0] base);
        start_done = done_cnt;
        start_rfw  = rfw_cnt;
        @(posedge clk);
        #1;
        save_i       = sv;
        restore_i    = rs;
        frame_base_i = base;
        @(posedge clk);
        #1;
        save_i    = 1'b0;
        restore_i = 1'b0;
        check("busy_rise", busy_o, 1'b1);
    endtask

    task automatic finish_op(input string name, input int rfw_exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_o && n < 300);
        check({name, "_idle_timeout"}, busy_o, 1'b0);
        check({name, "_done_count"}, done_cnt - start_done, 1);
        check({name, "_rf_writes"}, rfw_cnt - start_rfw, rfw_exp);
        check({name, "_store_q"}, exp_store.size(), 0);
        check({name, "_load_q"}, exp_load.size(), 0);
        check({name, "_rfw_q"}, exp_rfw.size(), 0);
        check({name, "_done_q"}, exp_done.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rfw_t w;
        int   n;
        int   stall0;
        save_i       = 1'b0;
        restore_i    = 1'b0;
        frame_base_i = '0;
        preload_rf(32'h0, 32'h0);

        // Reset state: every output 0.
        #12;
        check("reset_outputs", outs(), 128'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", busy_o, 1'b0);

        // Spill: r1..r31 preloaded 0x11..0x99, base 0x100, ready always high.
        preload_rf(32'h11, 32'h11);
        push_save(32'h100, 32'h11, 32'h11);
        exp_done.push_back(19);
        issue(1'b1, 1'b0, 32'h100);
        finish_op("spill", 0);

        // Fill: memory 0x200..0x220 holds 0xA0..0xA8, rvalid latency 1.
        for (int i = 0; i < 9; i++) begin
            mem_model[32'h200 + MW'(4 * i)] = 32'hA0 + DW'(i);
            exp_load.push_back(32'h200 + MW'(4 * i));
            w.addr = reg_of(i);
            w.data = 32'hA0 + DW'(i);
            exp_rfw.push_back(w);
        end
        exp_done.push_back(28);
        issue(1'b0, 1'b1, 32'h200);
        finish_op("fill", 9);

        // Backpressure: ready low 3 cycles on slot 4 (base+0x10) of a save.
        preload_rf(32'h5000, 32'h3);
        push_save(32'h180, 32'h5000, 32'h3);
        exp_done.push_back(22);
        stall_addr   = 32'h190;
        stall_cycles = 3;
        stall0       = stall_cnt;
        issue(1'b1, 1'b0, 32'h180);
        finish_op("backpressure", 0);
        check("backpressure_stall_cycles", stall_cnt - stall0, 3);
        stall_addr   = 32'h1;
        stall_cycles = 0;

        // Arbitration: both requests together -> save; restore while busy dropped.
        preload_rf(32'h7700, 32'h10);
        push_save(32'h300, 32'h7700, 32'h10);
        exp_done.push_back(19);
        issue(1'b1, 1'b1, 32'h300);
        repeat (3) @(posedge clk);
        #1;
        restore_i    = 1'b1;
        frame_base_i = 32'h500;
        @(posedge clk);
        #1;
        restore_i = 1'b0;
        finish_op("arbitration", 0);
        repeat (4) @(negedge clk);
        check("arbitration_no_second_op", busy_o, 1'b0);
        check("arbitration_single_done", done_cnt - start_done, 1);

        // Reset mid-fill: rst falls during FILL_WAIT of slot 3.
        for (int i = 0; i < 9; i++) mem_model[32'h400 + MW'(4 * i)] = 32'hB0 + DW'(i);
        for (int i = 0; i < 4; i++) exp_load.push_back(32'h400 + MW'(4 * i));
        for (int i = 0; i < 3; i++) begin
            w.addr = reg_of(i);
            w.data = 32'hB0 + DW'(i);
            exp_rfw.push_back(w);
        end
        block_addr = 32'h40C;
        issue(1'b0, 1'b1, 32'h400);
        n = 0;
        while (load_cnt - 0 < 0 || (exp_load.size() != 0 && n < 100)) begin
            @(negedge clk);
            n++;
        end
        check("reset_fill_reach_slot3", exp_load.size(), 0);
        @(posedge clk);
        #3;
        check("reset_fill_busy_before", busy_o, 1'b1);
        rst = 1'b0;
        #1;
        check("reset_async_outputs", outs(), 128'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (14) @(negedge clk);
        check("reset_idle_after", busy_o, 1'b0);
        check("reset_no_done", done_cnt - start_done, 0);
        check("reset_rf_writes", rfw_cnt - start_rfw, 3);
        check("reset_rfw_q", exp_rfw.size(), 0);
        check("reset_late_rvalid_consumed", rv_pending, 1'b0);
        block_addr = 32'h1;

        // Address wrap: base 0xFFFFFFF8 -> 0xFFFFFFF8, 0xFFFFFFFC, 0x0 ... 0x18.
        preload_rf(32'h1000, 32'h1);
        push_save(32'hFFFF_FFF8, 32'h1000, 32'h1);
        exp_done.push_back(19);
        issue(1'b1, 1'b0, 32'hFFFF_FFF8);
        finish_op("wrap", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
